// File: rtl/apb_regbank_if.sv
// APB bus bundle between master and the apb_regbank slave.
interface apb_regbank_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_W-1:0]     paddr;
  logic [DATA_W-1:0]     pwdata;
  logic [DATA_W/8-1:0]   pstrb;
  logic [DATA_W-1:0]     prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_regbank.sv
// Parametrised APB slave register bank with wait states, read-only status
// mapping and error responses. Optional byte strobes under APB_PSTRB_EN.
module apb_regbank #(
  parameter int unsigned          DATA_W      = 8,
  parameter int unsigned          NUM_REGS    = 4,
  parameter int unsigned          ADDR_W      = 4,
  parameter int unsigned          WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0]  RO_MASK     = '0,
  parameter logic [DATA_W-1:0]    RESET_VAL   = '0
) (
  input  logic                        pclk,
  input  logic                        presetn,
  apb_regbank_if.slave                bus,
  output logic [NUM_REGS*DATA_W-1:0]  reg_out,
  input  logic [NUM_REGS*DATA_W-1:0]  hw_in
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t              r_state;
  state_t              w_phase;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_regs [NUM_REGS];

  logic [NUM_REGS-1:0] w_sel;
  logic                w_addr_bad;
  logic                w_ro_hit;
  logic                w_done;
  logic                w_proto_err;
  logic                w_err;
  logic [DATA_W-1:0]   w_rdata;
  logic [DATA_W-1:0]   w_wmask;
  logic                w_unused;

  // An IDLE cycle that carries a setup request is the setup phase itself,
  // so a zero-wait transfer completes in the very next cycle.
  always_comb begin
    w_phase = r_state;
    if (r_state == IDLE && bus.psel && !bus.penable) begin
      w_phase = SETUP;
    end
  end

  assign w_done      = (r_state == ACCESS) && bus.psel && (r_cnt == '0);
  assign w_proto_err = (r_state == IDLE) && bus.psel && bus.penable;

  // Address decode and read mux; an unmatched address leaves w_rdata at 0.
  always_comb begin
    w_sel    = '0;
    w_ro_hit = 1'b0;
    w_rdata  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_sel[i] = (bus.paddr == ADDR_W'(i));
      if (w_sel[i]) begin
        w_ro_hit = RO_MASK[i];
        w_rdata  = RO_MASK[i] ? hw_in[i*DATA_W +: DATA_W] : r_regs[i];
      end
    end
  end

  assign w_addr_bad = ~|w_sel;
  assign w_err      = w_addr_bad | (bus.pwrite & w_ro_hit);

`ifdef APB_PSTRB_EN
  always_comb begin
    w_wmask = '0;
    for (int b = 0; b < DATA_W/8; b++) begin
      w_wmask[b*8 +: 8] = {8{bus.pstrb[b]}};
    end
  end
`else
  assign w_wmask = '1;
`endif

  assign bus.pready  = w_done | w_proto_err;
  assign bus.pslverr = (w_done & w_err) | w_proto_err;
  assign bus.prdata  = (w_done && !bus.pwrite) ? w_rdata : '0;

  // Transfer sequencing, wait counter and register storage.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= RESET_VAL;
      end
    end else begin
      case (w_phase)
        IDLE: begin
          r_state <= IDLE;
        end
        SETUP: begin
          r_state <= ACCESS;
          r_cnt   <= CNT_W'(WAIT_STATES);
        end
        ACCESS: begin
          if (!bus.psel) begin
            r_state <= IDLE;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_state <= bus.penable ? IDLE : SETUP;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase

      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_done && bus.pwrite && !w_err && w_sel[i] && !RO_MASK[i]) begin
          r_regs[i] <= (r_regs[i] & ~w_wmask) | (bus.pwdata & w_wmask);
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign reg_out[g*DATA_W +: DATA_W] = r_regs[g];
  end

  // hw_in slices of writable registers and, without strobes, pstrb are unused.
  assign w_unused = ^{bus.pstrb, hw_in};

endmodule

// File: tb/tb_apb_regbank.sv
// Directed scoreboard bench for apb_regbank across three parameter sets.
module tb_apb_regbank;

  logic        pclk;
  logic        presetn;
  logic        psel, penable, pwrite;
  logic [3:0]  paddr;
  logic [15:0] pwdata;
  logic [1:0]  pstrb;
  int          sel;

  logic [31:0] reg_out_a, reg_out_c;
  logic [63:0] reg_out_b;
  logic [31:0] hw_in_a = '0;
  logic [31:0] hw_in_c = '0;
  logic [63:0] hw_in_b;

  logic        obs_ready, obs_err;
  logic [15:0] obs_rd;
  logic [63:0] obs_reg;
  logic [63:0] reg_at_done;

  typedef struct {
    logic [15:0] rd;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb_q[$];

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

`ifdef APB_PSTRB_EN
  localparam logic [15:0] E_S1 = 16'h0034;
  localparam logic [15:0] E_S2 = 16'hAB34;
  localparam logic [15:0] E_S3 = 16'hAB34;
`else
  localparam logic [15:0] E_S1 = 16'h1234;
  localparam logic [15:0] E_S2 = 16'hABCD;
  localparam logic [15:0] E_S3 = 16'hFFFF;
`endif

  apb_regbank_if #(.ADDR_W(4), .DATA_W(8))  if_a ();
  apb_regbank_if #(.ADDR_W(4), .DATA_W(16)) if_b ();
  apb_regbank_if #(.ADDR_W(4), .DATA_W(8))  if_c ();

  assign if_a.psel    = psel & (sel == 0);
  assign if_a.penable = penable;
  assign if_a.pwrite  = pwrite;
  assign if_a.paddr   = paddr;
  assign if_a.pwdata  = pwdata[7:0];
  assign if_a.pstrb   = pstrb[0];

  assign if_b.psel    = psel & (sel == 1);
  assign if_b.penable = penable;
  assign if_b.pwrite  = pwrite;
  assign if_b.paddr   = paddr;
  assign if_b.pwdata  = pwdata;
  assign if_b.pstrb   = pstrb;

  assign if_c.psel    = psel & (sel == 2);
  assign if_c.penable = penable;
  assign if_c.pwrite  = pwrite;
  assign if_c.paddr   = paddr;
  assign if_c.pwdata  = pwdata[7:0];
  assign if_c.pstrb   = pstrb[0];

  apb_regbank u_a (
    .pclk(pclk), .presetn(presetn), .bus(if_a.slave),
    .reg_out(reg_out_a), .hw_in(hw_in_a)
  );

  apb_regbank #(
    .DATA_W(16), .NUM_REGS(4), .ADDR_W(4), .WAIT_STATES(2),
    .RO_MASK(4'b0100), .RESET_VAL(16'h0000)
  ) u_b (
    .pclk(pclk), .presetn(presetn), .bus(if_b.slave),
    .reg_out(reg_out_b), .hw_in(hw_in_b)
  );

  apb_regbank #(
    .DATA_W(8), .NUM_REGS(4), .ADDR_W(4), .WAIT_STATES(3),
    .RO_MASK(4'b0000), .RESET_VAL(8'h3C)
  ) u_c (
    .pclk(pclk), .presetn(presetn), .bus(if_c.slave),
    .reg_out(reg_out_c), .hw_in(hw_in_c)
  );

  always_comb begin
    obs_ready = if_a.pready;
    obs_err   = if_a.pslverr;
    obs_rd    = 16'(if_a.prdata);
    obs_reg   = 64'(reg_out_a);
    case (sel)
      1: begin
        obs_ready = if_b.pready;
        obs_err   = if_b.pslverr;
        obs_rd    = if_b.prdata;
        obs_reg   = reg_out_b;
      end
      2: begin
        obs_ready = if_c.pready;
        obs_err   = if_c.pslverr;
        obs_rd    = 16'(if_c.prdata);
        obs_reg   = 64'(reg_out_c);
      end
      default: ;
    endcase
  end

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One full APB transfer; expectation is queued at issue, checked at pready.
  task automatic xfer(input int d, input logic wr, input logic [3:0] a,
                      input logic [15:0] wd, input logic [1:0] st,
                      input logic [15:0] e_rd, input logic e_err, input int e_lat);
    exp_t e;
    int   lat;
    logic done;
    sb_q.push_back('{rd: e_rd, err: e_err, lat: e_lat});
    sel = d; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
    @(negedge pclk);
    chk("setup_pready", 64'(obs_ready), 64'd0);
    @(posedge pclk); #1;
    penable = 1'b1;
    lat = 0;
    done = 1'b0;
    while (!done && lat < 20) begin
      @(negedge pclk);
      lat++;
      if (obs_ready) begin
        done = 1'b1;
        reg_at_done = obs_reg;
        e = sb_q.pop_front();
        chk("prdata", 64'(obs_rd), 64'(e.rd));
        chk("pslverr", 64'(obs_err), 64'(e.err));
        chk("latency", 64'(lat), 64'(e.lat));
      end
      @(posedge pclk); #1;
    end
    if (!done) begin
      void'(sb_q.pop_front());
      chk("timeout", 64'(done), 64'd1);
    end
    psel = 1'b0; penable = 1'b0;
  endtask

  logic [7:0] d1 [4];

  initial begin
    presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; sel = 0;
    hw_in_b = 64'h0000_00C3_0000_0000;
    d1[0] = 8'hDE; d1[1] = 8'hAD; d1[2] = 8'hBE; d1[3] = 8'hEF;
    reg_at_done = '0;

    repeat (2) @(posedge pclk);
    @(negedge pclk);
    chk("rst_pready", 64'(obs_ready), 64'd0);
    chk("rst_pslverr", 64'(obs_err), 64'd0);
    chk("rst_prdata", 64'(obs_rd), 64'd0);
    chk("rst_reg_a", 64'(reg_out_a), 64'd0);
    chk("rst_reg_c", 64'(reg_out_c), 64'h3C3C3C3C);
    @(posedge pclk); #1;
    presetn = 1'b1;
    @(posedge pclk); #1;

    // Default configuration: back-to-back writes then reads.
    for (int i = 0; i < 4; i++) xfer(0, 1'b1, 4'(i), 16'(d1[i]), 2'b11, 16'h0, 1'b0, 1);
    for (int i = 0; i < 4; i++) xfer(0, 1'b0, 4'(i), 16'h0, 2'b11, 16'(d1[i]), 1'b0, 1);
    chk("reg_out_a", 64'(reg_out_a), 64'hEFBEADDE);

    xfer(0, 1'b1, 4'd5, 16'h0077, 2'b11, 16'h0, 1'b1, 1);
    chk("oor_wr_regs", 64'(reg_out_a), 64'hEFBEADDE);
    xfer(0, 1'b0, 4'd5, 16'h0, 2'b11, 16'h0, 1'b1, 1);

    // Enable without a setup phase.
    sel = 0; psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 4'd0; pwdata = 16'h0055;
    @(negedge pclk);
    chk("proto_pready", 64'(obs_ready), 64'd1);
    chk("proto_pslverr", 64'(obs_err), 64'd1);
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    chk("proto_regs", 64'(reg_out_a), 64'hEFBEADDE);
    xfer(0, 1'b0, 4'd0, 16'h0, 2'b11, 16'h00DE, 1'b0, 1);

    // Wait states and read-only status register.
    xfer(1, 1'b1, 4'd1, 16'h005A, 2'b11, 16'h0, 1'b0, 3);
    chk("ws_before_edge", 64'(reg_at_done[31:16]), 64'h0);
    chk("ws_after_edge", 64'(reg_out_b[31:16]), 64'h005A);
    xfer(1, 1'b0, 4'd2, 16'h0, 2'b11, 16'h00C3, 1'b0, 3);
    xfer(1, 1'b1, 4'd2, 16'h0011, 2'b11, 16'h0, 1'b1, 3);
    xfer(1, 1'b0, 4'd2, 16'h0, 2'b11, 16'h00C3, 1'b0, 3);
    hw_in_b = 64'h0000_00A5_0000_0000;
    xfer(1, 1'b0, 4'd2, 16'h0, 2'b11, 16'h00A5, 1'b0, 3);

    // Byte strobes on a 16-bit bank.
    xfer(1, 1'b1, 4'd0, 16'h1234, 2'b01, 16'h0, 1'b0, 3);
    chk("strb_lo", 64'(reg_out_b[15:0]), 64'(E_S1));
    xfer(1, 1'b1, 4'd0, 16'hABCD, 2'b10, 16'h0, 1'b0, 3);
    chk("strb_hi", 64'(reg_out_b[15:0]), 64'(E_S2));
    xfer(1, 1'b1, 4'd0, 16'hFFFF, 2'b00, 16'h0, 1'b0, 3);
    chk("strb_none", 64'(reg_out_b[15:0]), 64'(E_S3));

    // psel dropped mid-access aborts the write.
    sel = 2; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'd1; pwdata = 16'h0099;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge pclk);
    chk("abort_pready", 64'(obs_ready), 64'd0);
    @(posedge pclk); #1;
    chk("abort_regs", 64'(reg_out_c), 64'h3C3C3C3C);
    xfer(2, 1'b0, 4'd1, 16'h0, 2'b11, 16'h003C, 1'b0, 4);

    // Reset in the middle of a waiting write.
    sel = 2; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'd0; pwdata = 16'h00FF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    presetn = 1'b0; psel = 1'b0; penable = 1'b0;
    @(negedge pclk);
    chk("midrst_reg0", 64'(reg_out_c[7:0]), 64'h3C);
    chk("midrst_pready", 64'(obs_ready), 64'd0);
    chk("midrst_reg_a", 64'(reg_out_a), 64'd0);
    @(posedge pclk); #1;
    presetn = 1'b1;
    @(posedge pclk);
    @(posedge pclk); #1;
    xfer(2, 1'b1, 4'd0, 16'h0042, 2'b11, 16'h0, 1'b0, 4);
    chk("post_rst_wr", 64'(reg_out_c[7:0]), 64'h42);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
